// File: rtl/hard_mem_1rw_rr_share_ctrl.sv
// hard_mem_1rw_rr_share_ctrl: round-robin share of one 1RW hard memory between two requesters,
// with a post-reset zero-fill of the whole array before arbitration goes live.
module hard_mem_1rw_rr_share_ctrl #(
  parameter int DW        = 64,
  parameter int AW        = 9,
  parameter int INIT_ZERO = 1
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          a_v_i,
  input  logic          a_w_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_data_i,
  input  logic [DW-1:0] a_w_mask_i,
  output logic          a_ready_o,
  output logic          a_v_o,
  output logic [DW-1:0] a_data_o,
  input  logic          b_v_i,
  input  logic          b_w_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] b_data_i,
  input  logic [DW-1:0] b_w_mask_i,
  output logic          b_ready_o,
  output logic          b_v_o,
  output logic [DW-1:0] b_data_o,
  output logic          mem_v_o,
  output logic          mem_w_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  output logic [DW-1:0] mem_w_mask_o,
  input  logic [DW-1:0] mem_data_i,
  output logic          init_done_o
);
  typedef enum logic {INIT, RUN} state_e;
  localparam state_e RST_STATE = (INIT_ZERO != 0) ? INIT : RUN;
  localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};
  state_e state_q, state_d;
  logic [AW:0] init_ptr_q, init_ptr_d;
  logic prio_q, prio_d;
  logic a_pend_q, a_pend_d, b_pend_q, b_pend_d;
  logic run, init, gnt_a, gnt_b;
  // Outputs are gated by reset_n_i so every output reads 0 while reset is held.
  always_comb begin
    run          = reset_n_i & (state_q == RUN);
    init         = reset_n_i & (state_q == INIT);
    gnt_a        = run & a_v_i & (~b_v_i | ~prio_q);
    gnt_b        = run & b_v_i & (~a_v_i | prio_q);
    a_ready_o    = gnt_a;
    b_ready_o    = gnt_b;
    init_done_o  = run;
    mem_v_o      = init | gnt_a | gnt_b;
    mem_w_o      = init | (gnt_a & a_w_i) | (gnt_b & b_w_i);
    mem_addr_o   = init ? init_ptr_q[AW-1:0] : gnt_a ? a_addr_i : gnt_b ? b_addr_i : '0;
    mem_data_o   = init ? '0 : gnt_a ? a_data_i : gnt_b ? b_data_i : '0;
    mem_w_mask_o = init ? '1 : (gnt_a & a_w_i) ? a_w_mask_i : (gnt_b & b_w_i) ? b_w_mask_i : '0;
    a_v_o        = a_pend_q;
    b_v_o        = b_pend_q;
    a_data_o     = a_pend_q ? mem_data_i : '0;
    b_data_o     = b_pend_q ? mem_data_i : '0;
    state_d      = (state_q == INIT && init_ptr_q == LAST) ? RUN : state_q;
    init_ptr_d   = (state_q == INIT) ? init_ptr_q + 1'b1 : init_ptr_q;
    prio_d       = gnt_a ? 1'b1 : gnt_b ? 1'b0 : prio_q;
    a_pend_d     = gnt_a & ~a_w_i;
    b_pend_d     = gnt_b & ~b_w_i;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= RST_STATE;
      init_ptr_q <= '0;
      prio_q     <= 1'b0;
      a_pend_q   <= 1'b0;
      b_pend_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      prio_q     <= prio_d;
      a_pend_q   <= a_pend_d;
      b_pend_q   <= b_pend_d;
    end
  end
endmodule

// File: tb/tb_hard_mem_1rw_rr_share_ctrl.sv
// tb_hard_mem_1rw_rr_share_ctrl: vector table plus hand-written reset/INIT sequences,
// read responses checked against a scoreboard fed from a reference memory.
module tb_hard_mem_1rw_rr_share_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
  typedef struct {
    logic av, aw; logic [AW-1:0] aa; logic [DW-1:0] ad, am;
    logic bv, bw; logic [AW-1:0] ba; logic [DW-1:0] bd, bm;
    logic ea, eb;
  } vec_t;
  typedef struct { logic side; logic [DW-1:0] data; } rsp_t;
  logic clk = 0, reset_n = 0, z_rst_n = 0;
  logic a_v = 0, a_w = 0, b_v = 0, b_w = 0, z_a_v = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, a_mask = '0, b_data = '0, b_mask = '0;
  logic a_ready, a_v_o, b_ready, b_v_o, mem_v, mem_w, init_done;
  logic [DW-1:0] a_data_o, b_data_o, mem_data_o, mem_mask, mem_rd;
  logic [AW-1:0] mem_addr;
  logic z_a_ready, z_a_v_o, z_b_ready, z_b_v_o, z_mem_v, z_mem_w, z_done;
  logic [DW-1:0] z_a_data_o, z_b_data_o, z_mem_data_o, z_mem_mask;
  logic [AW-1:0] z_mem_addr;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] ref_mem [16];
  bit seeded = 0;
  rsp_t sb[$];
  vec_t vt[13];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  hard_mem_1rw_rr_share_ctrl #(.DW(DW), .AW(AW), .INIT_ZERO(1)) u_dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .a_v_i(a_v), .a_w_i(a_w), .a_addr_i(a_addr), .a_data_i(a_data), .a_w_mask_i(a_mask),
    .a_ready_o(a_ready), .a_v_o(a_v_o), .a_data_o(a_data_o),
    .b_v_i(b_v), .b_w_i(b_w), .b_addr_i(b_addr), .b_data_i(b_data), .b_w_mask_i(b_mask),
    .b_ready_o(b_ready), .b_v_o(b_v_o), .b_data_o(b_data_o),
    .mem_v_o(mem_v), .mem_w_o(mem_w), .mem_addr_o(mem_addr), .mem_data_o(mem_data_o),
    .mem_w_mask_o(mem_mask), .mem_data_i(mem_rd), .init_done_o(init_done));
  hard_mem_1rw_rr_share_ctrl #(.DW(DW), .AW(AW), .INIT_ZERO(0)) u_dut_noinit (
    .clk_i(clk), .reset_n_i(z_rst_n),
    .a_v_i(z_a_v), .a_w_i(1'b0), .a_addr_i(4'd3), .a_data_i(32'h0), .a_w_mask_i(32'h0),
    .a_ready_o(z_a_ready), .a_v_o(z_a_v_o), .a_data_o(z_a_data_o),
    .b_v_i(1'b0), .b_w_i(1'b0), .b_addr_i(4'd0), .b_data_i(32'h0), .b_w_mask_i(32'h0),
    .b_ready_o(z_b_ready), .b_v_o(z_b_v_o), .b_data_o(z_b_data_o),
    .mem_v_o(z_mem_v), .mem_w_o(z_mem_w), .mem_addr_o(z_mem_addr), .mem_data_o(z_mem_data_o),
    .mem_w_mask_o(z_mem_mask), .mem_data_i(32'h0), .init_done_o(z_done));
  // Memory starts with garbage so the zero-fill is observable.
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | i;
      seeded <= 1;
    end else if (mem_v) begin
      if (mem_w) mem[mem_addr] <= (mem[mem_addr] & ~mem_mask) | (mem_data_o & mem_mask);
      else mem_rd <= mem[mem_addr];
    end
  end
  task automatic chk(string n, logic [DW-1:0] act, logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    rsp_t r;
    if (a_v_o || b_v_o) begin
      chk("one_rsp", {31'b0, a_v_o & b_v_o}, 32'h0);
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL rsp_unexpected: got a_v_o=%0d b_v_o=%0d expected none", a_v_o, b_v_o);
      end else begin
        r = sb.pop_front();
        chk("rsp_side", {31'b0, b_v_o}, {31'b0, r.side});
        chk("rsp_data", r.side ? b_data_o : a_data_o, r.data);
      end
    end
    if (!a_v_o) chk("a_data_idle", a_data_o, 32'h0);
    if (!b_v_o) chk("b_data_idle", b_data_o, 32'h0);
  end
  function automatic vec_t mk(logic av, aw, logic [AW-1:0] aa, logic [DW-1:0] ad, am,
                              logic bv, bw, logic [AW-1:0] ba, logic [DW-1:0] bd, bm,
                              logic ea, eb);
    vec_t v;
    v.av = av; v.aw = aw; v.aa = aa; v.ad = ad; v.am = am;
    v.bv = bv; v.bw = bw; v.ba = ba; v.bd = bd; v.bm = bm;
    v.ea = ea; v.eb = eb;
    return v;
  endfunction
  task automatic set_in(vec_t v);
    a_v = v.av; a_w = v.aw; a_addr = v.aa; a_data = v.ad; a_mask = v.am;
    b_v = v.bv; b_w = v.bw; b_addr = v.ba; b_data = v.bd; b_mask = v.bm;
  endtask
  task automatic accept(logic side, logic w, logic [AW-1:0] addr, logic [DW-1:0] d, logic [DW-1:0] m);
    rsp_t r;
    if (w) ref_mem[addr] = (ref_mem[addr] & ~m) | (d & m);
    else begin
      r.side = side; r.data = ref_mem[addr];
      sb.push_back(r);
    end
  endtask
  task automatic init_seq(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("init_v", {31'b0, mem_v}, 32'h1);
      chk("init_w", {31'b0, mem_w}, 32'h1);
      chk("init_addr", {28'b0, mem_addr}, i);
      chk("init_data", mem_data_o, 32'h0);
      chk("init_mask", mem_mask, 32'hFFFF_FFFF);
      chk("init_rdy", {30'b0, a_ready, b_ready}, 32'h0);
      chk("init_done_low", {31'b0, init_done}, 32'h0);
      if (i < n - 1) begin @(posedge clk); #1; end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v;
    logic [DW-1:0] e_addr, e_data, e_mask;
    vt[0]  = mk(1, 1, 5, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 0);
    vt[1]  = mk(1, 0, 5, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 0);
    vt[2]  = mk(1, 0, 6, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, 1, 1, 9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    vt[4]  = mk(0, 0, 0, 0, 0, 1, 1, 9, 32'h1234_5678, 32'h0000_00FF, 0, 1);
    vt[5]  = mk(0, 0, 0, 0, 0, 1, 0, 9, 32'h0, 32'hFFFF_FFFF, 0, 1);
    for (int i = 0; i < 6; i++)
      vt[6 + i] = mk(1, 0, 5, 32'h0, 32'hFFFF_FFFF, 1, 0, 9, 32'h0, 32'hFFFF_FFFF, (i % 2) == 0, (i % 2) == 1);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Both requesters hold requests through reset and INIT; neither may be dropped.
    a_v = 1; a_w = 0; a_addr = 6; a_mask = 32'hFFFF_FFFF;
    b_v = 1; b_w = 1; b_addr = 3; b_data = 32'h1111_1111; b_mask = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_v", {31'b0, mem_v}, 32'h0);
    chk("rst_mem_mask", mem_mask, 32'h0);
    chk("rst_rdy", {30'b0, a_ready, b_ready}, 32'h0);
    chk("rst_done", {31'b0, init_done}, 32'h0);
    chk("rst_rsp", {30'b0, a_v_o, b_v_o}, 32'h0);
    @(posedge clk); #1 reset_n = 1;
    init_seq(16);
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_after_init", {31'b0, init_done}, 32'h1);
    chk("held_a_rdy", {30'b0, a_ready, b_ready}, 32'h2);
    chk("held_a_mem", {mem_v, mem_w, 2'b0, mem_addr}, 32'h86);
    chk("read_mask_zero", mem_mask, 32'h0);
    accept(0, 0, 6, 0, 0);
    @(posedge clk); #1 a_v = 0;
    @(negedge clk);
    chk("held_b_rdy", {30'b0, a_ready, b_ready}, 32'h1);
    chk("held_b_mem", {mem_v, mem_w, 2'b0, mem_addr}, 32'hC3);
    accept(1, 1, 3, 32'h1111_1111, 32'hFFFF_FFFF);
    @(posedge clk); #1 b_v = 0;
    for (int i = 0; i < 13; i++) begin
      v = vt[i];
      set_in(v);
      @(negedge clk);
      e_addr = v.ea ? {28'b0, v.aa} : v.eb ? {28'b0, v.ba} : 32'h0;
      e_data = v.ea ? v.ad : v.eb ? v.bd : 32'h0;
      e_mask = (v.ea & v.aw) ? v.am : (v.eb & v.bw) ? v.bm : 32'h0;
      chk($sformatf("v%0d_rdy", i), {30'b0, a_ready, b_ready}, {30'b0, v.ea, v.eb});
      chk($sformatf("v%0d_mem_vw", i), {30'b0, mem_v, mem_w}, {30'b0, v.ea | v.eb, (v.ea & v.aw) | (v.eb & v.bw)});
      chk($sformatf("v%0d_addr", i), {28'b0, mem_addr}, e_addr);
      chk($sformatf("v%0d_data", i), mem_data_o, e_data);
      chk($sformatf("v%0d_mask", i), mem_mask, e_mask);
      if (v.ea) accept(0, v.aw, v.aa, v.ad, v.am);
      if (v.eb) accept(1, v.bw, v.ba, v.bd, v.bm);
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1 chk("sb_drained", sb.size(), 32'h0);
    // Reset lands while a read response is pending.
    a_v = 1; a_w = 0; a_addr = 9;
    @(negedge clk);
    chk("pend_rdy", {31'b0, a_ready}, 32'h1);
    accept(0, 0, 9, 0, 0);
    @(posedge clk); #1 reset_n = 0;
    sb.delete();
    #1;
    chk("pend_rst_rsp", {30'b0, a_v_o, b_v_o}, 32'h0);
    chk("pend_rst_mem_v", {31'b0, mem_v}, 32'h0);
    chk("pend_rst_rdy", {31'b0, a_ready}, 32'h0);
    chk("pend_rst_done", {31'b0, init_done}, 32'h0);
    a_v = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    init_seq(8);
    reset_n = 0;
    #1;
    chk("midinit_mem_v", {31'b0, mem_v}, 32'h0);
    chk("midinit_addr", {28'b0, mem_addr}, 32'h0);
    chk("midinit_w", {31'b0, mem_w}, 32'h0);
    @(posedge clk); #1 reset_n = 1;
    init_seq(16);
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    @(posedge clk); #1;
    b_v = 1; b_w = 0; b_addr = 9;
    @(negedge clk);
    chk("reinit_done", {31'b0, init_done}, 32'h1);
    chk("reinit_b_rdy", {31'b0, b_ready}, 32'h1);
    accept(1, 0, 9, 0, 0);
    @(posedge clk); #1 b_v = 0;
    repeat (3) @(posedge clk);
    #1 chk("sb_drained2", sb.size(), 32'h0);
    // INIT_ZERO=0 instance: arbitration live in the first cycle after release.
    z_a_v = 1;
    @(negedge clk);
    chk("z_rst_done", {31'b0, z_done}, 32'h0);
    chk("z_rst_rdy", {31'b0, z_a_ready}, 32'h0);
    @(posedge clk); #1 z_rst_n = 1;
    @(negedge clk);
    chk("z_done", {31'b0, z_done}, 32'h1);
    chk("z_rdy", {31'b0, z_a_ready}, 32'h1);
    chk("z_mem", {z_mem_v, z_mem_w, 2'b0, z_mem_addr}, 32'h83);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
